mmm_redc_256b_3way: RTL and testbench
=====================================

MMM_REDC_256B_3WAY -- requirements
Module: mmm_redc_256b_3way

Interface
REQ-001 Parameter: IDW, 256, width of modulus and reduced result.
REQ-002 Parameter: DIVW, 87, digit width; the radix is 2^DIVW.
REQ-003 Parameter: ODW, 522, width of the unreduced product input (the 3-way Karatsuba stage-1 output T).
REQ-004 Port: i_clk  input  1  single clock; all state changes on its rising edge.
REQ-005 Port: i_rstn  input  1  reset; synchronous, active-low.
REQ-006 Port: i_valid  input  1  upstream presents a product on i_t.
REQ-007 Port: o_ready  output  1  block can accept a product.
REQ-008 Port: i_t  input  ODW  unreduced product T; T < m*2^(3*DIVW).
REQ-009 Port: i_m  input  IDW  odd modulus m, sampled with i_t.
REQ-010 Port: i_minv  input  DIVW  m' = -m^-1 mod 2^DIVW, sampled with i_t.
REQ-011 Port: o_valid  output  1  o_res holds a finished result.
REQ-012 Port: i_ready  input  1  downstream accepts o_res.
REQ-013 Port: o_res  output  IDW+1  reduced result, T*2^(-3*DIVW) mod m.

Function
REQ-014 FSM states: IDLE, ITER, SUB, DONE; encoding is free.
REQ-015 o_ready SHALL be 1 only in IDLE, and o_valid SHALL be 1 only in DONE.
REQ-016 Accept occurs when i_valid&&o_ready at a clock edge: acc <= zero-extended i_t (ODW+2 bits), m and m' are latched, digit counter cleared, and the FSM moves to ITER.
REQ-017 Each ITER cycle: q = (acc[DIVW-1:0]*m') mod 2^DIVW; acc <= (acc + q*m) >> DIVW; counter +1; exactly one digit per cycle.
REQ-018 After the third ITER cycle, the FSM SHALL go to SUB (macro defined) or DONE (macro undefined).
REQ-019 SUB, one cycle: o_res <= (acc >= m) ? acc-m : acc; then go to DONE.
REQ-020 Latency: accept at edge N; o_valid rises in cycle N+5 with the macro defined, N+4 without.
REQ-021 In DONE, o_res and o_valid SHALL hold stable until i_ready=1; at that edge the FSM returns to IDLE.
REQ-022 There is no accept/complete bypass: o_ready first rises the cycle after the output handshake.
REQ-023 i_t, i_m and i_minv SHALL be ignored outside the accept edge; changes mid-operation have no effect.
REQ-024 The intermediate sum acc+q*m SHALL be computed at full width with no truncation before the shift.

Reset
REQ-025 While i_rstn=0 at an edge: FSM <= IDLE, o_valid=0, o_ready=1 next cycle, o_res=0, acc=0, counter=0.
REQ-026 Reset in any state, including mid-ITER or DONE under backpressure, SHALL abort the operation with no output produced.

Configuration
REQ-027 Macro MMM_REDC_FINAL_SUB_EN defined: the SUB state is present, and o_res < m with o_res[IDW]=0.
REQ-028 Macro MMM_REDC_FINAL_SUB_EN undefined: the SUB state is removed, o_res = acc in [0, 2m), and latency is reduced by one cycle.

Verification
REQ-029 m=2^255-19, T=0 -> o_res=0, o_valid at accept+5 (accept+4 without the macro).
REQ-030 m=2^255-19, T=2^261 -> o_res=1.
REQ-031 m=2^255-19, T=m -> o_res=0 with the macro; o_res=m without it.
REQ-032 Random T<m*2^261 and random odd m (1000 vectors) -> o_res matches the golden model T*2^-261 mod m; i_ready held 0 for 10 cycles -> o_res stable, o_ready=0.
REQ-033 i_rstn=0 for one cycle during the second ITER cycle -> next cycle o_valid=0, o_ready=1, o_res=0; a new accept then completes correctly.
REQ-034 Back-to-back i_valid=1 with i_ready=1 -> one accept every 6 cycles (macro defined) and no dropped or duplicated results.

Source files
------------

// File: rtl/mmm_redc_256b_3way.sv
// Montgomery REDC of a 3-way Karatsuba product, one 87-bit digit per cycle.
// Optional final conditional subtraction stage: define MMM_REDC_FINAL_SUB_EN.
module mmm_redc_256b_3way #(
    parameter int IDW  = 256,
    parameter int DIVW = 87,
    parameter int ODW  = 522
) (
    input  logic            i_clk,
    input  logic            i_rstn,
    input  logic            i_valid,
    output logic            o_ready,
    input  logic [ODW-1:0]  i_t,
    input  logic [IDW-1:0]  i_m,
    input  logic [DIVW-1:0] i_minv,
    output logic            o_valid,
    input  logic            i_ready,
    output logic [IDW:0]    o_res
);

    localparam int ACCW = ODW + 2;
    localparam int SUMW = ACCW + 1;
    localparam int QMW  = DIVW + IDW;

    typedef enum logic [1:0] {
        IDLE,
        ITER,
`ifdef MMM_REDC_FINAL_SUB_EN
        SUB,
`endif
        DONE
    } state_t;

    state_t          state;
    logic [ACCW-1:0] acc;
    logic [IDW-1:0]  m_r;
    logic [DIVW-1:0] minv_r;
    logic [1:0]      cnt;

    logic [DIVW-1:0] q;
    logic [QMW-1:0]  qm;
    logic [SUMW-1:0] sum;
    logic [ACCW-1:0] acc_nxt;

    // One REDC digit step; the sum carries one extra bit so nothing is lost before the shift.
    always_comb begin
        q       = acc[DIVW-1:0] * minv_r;
        qm      = q * m_r;
        sum     = SUMW'(acc) + SUMW'(qm);
        acc_nxt = ACCW'(sum >> DIVW);
    end

    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            state   <= IDLE;
            o_ready <= 1'b1;
            o_valid <= 1'b0;
            o_res   <= '0;
            acc     <= '0;
            cnt     <= '0;
            m_r     <= '0;
            minv_r  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (i_valid && o_ready) begin
                        acc     <= ACCW'(i_t);
                        m_r     <= i_m;
                        minv_r  <= i_minv;
                        cnt     <= '0;
                        o_ready <= 1'b0;
                        state   <= ITER;
                    end
                end
                ITER: begin
                    acc <= acc_nxt;
                    cnt <= cnt + 2'd1;
                    if (cnt == 2'd2) begin
`ifdef MMM_REDC_FINAL_SUB_EN
                        state   <= SUB;
`else
                        o_res   <= (IDW+1)'(acc_nxt);
                        o_valid <= 1'b1;
                        state   <= DONE;
`endif
                    end
                end
`ifdef MMM_REDC_FINAL_SUB_EN
                SUB: begin
                    if (acc >= ACCW'(m_r))
                        o_res <= (IDW+1)'(acc - ACCW'(m_r));
                    else
                        o_res <= (IDW+1)'(acc);
                    o_valid <= 1'b1;
                    state   <= DONE;
                end
`endif
                DONE: begin
                    if (i_ready) begin
                        o_valid <= 1'b0;
                        o_ready <= 1'b1;
                        state   <= IDLE;
                    end
                end
                default: begin
                    o_valid <= 1'b0;
                    o_ready <= 1'b1;
                    state   <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mmm_redc_256b_3way.sv
// Directed bench for mmm_redc_256b_3way; results checked modulo m against hand-built T = r*2^261 + k*m.
module tb_mmm_redc_256b_3way;

    localparam int IDW  = 256;
    localparam int DIVW = 87;
    localparam int ODW  = 522;
`ifdef MMM_REDC_FINAL_SUB_EN
    localparam int LAT = 4;
`else
    localparam int LAT = 3;
`endif
    localparam int PERIOD = LAT + 2;

    logic            i_clk;
    logic            i_rstn;
    logic            i_valid;
    logic            o_ready;
    logic [ODW-1:0]  i_t;
    logic [IDW-1:0]  i_m;
    logic [DIVW-1:0] i_minv;
    logic            o_valid;
    logic            i_ready;
    logic [IDW:0]    o_res;

    mmm_redc_256b_3way #(.IDW(IDW), .DIVW(DIVW), .ODW(ODW)) dut (
        .i_clk   (i_clk),
        .i_rstn  (i_rstn),
        .i_valid (i_valid),
        .o_ready (o_ready),
        .i_t     (i_t),
        .i_m     (i_m),
        .i_minv  (i_minv),
        .o_valid (o_valid),
        .i_ready (i_ready),
        .o_res   (o_res)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [IDW:0] got, input logic [IDW:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [255:0] rnd256();
        logic [255:0] v;
        for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom();
        return v;
    endfunction

    // Newton iteration doubles correct low bits each step: 3 -> 96 >= 87.
    function automatic logic [DIVW-1:0] neg_inv(input logic [IDW-1:0] m);
        logic [DIVW-1:0] x;
        logic [DIVW-1:0] m87;
        m87 = m[DIVW-1:0];
        x   = m87;
        for (int i = 0; i < 6; i++) x = x * (DIVW'(2) - m87 * x);
        return -x;
    endfunction

    function automatic logic [IDW:0] norm(input logic [IDW:0] res, input logic [IDW-1:0] m);
`ifdef MMM_REDC_FINAL_SUB_EN
        return res;
`else
        return (res >= (IDW+1)'(m)) ? res - (IDW+1)'(m) : res;
`endif
    endfunction

    task automatic run_op(input logic [ODW-1:0] t, input logic [IDW-1:0] m,
                          output logic [IDW:0] res, output int lat);
        int w;
        w = 0;
        while (!o_ready && w < 20) begin @(posedge i_clk); #1; w++; end
        i_t = t; i_m = m; i_minv = neg_inv(m);
        i_valid = 1'b1; i_ready = 1'b1;
        @(posedge i_clk); #1;
        i_valid = 1'b0;
        i_t     = {rnd256(), rnd256(), 10'($urandom())};
        i_m     = rnd256();
        i_minv  = DIVW'({$urandom(), $urandom(), $urandom()});
        lat = 0;
        while (!o_valid && lat < 20) begin @(posedge i_clk); #1; lat++; end
        res = o_res;
        @(posedge i_clk); #1;
    endtask

    logic [IDW-1:0]  m_p;
    logic [IDW-1:0]  m_r;
    logic [IDW-1:0]  r_r;
    logic [258:0]    k_r;
    logic [ODW-1:0]  t_r;
    logic [IDW:0]    res;
    logic [IDW:0]    bexp [4];
    logic [ODW-1:0]  bt   [4];
    int              lat;

    initial begin
        int w, nin, nout, cyc, last;
        logic afire, ofire;

        m_p     = (IDW'(1) << 255) - IDW'(19);
        i_rstn  = 1'b0; i_valid = 1'b0; i_ready = 1'b0;
        i_t     = '0;   i_m = '0;       i_minv = '0;
        repeat (2) @(posedge i_clk);
        #1;
        chk("rst_ready", (IDW+1)'(o_ready), 1);
        chk("rst_valid", (IDW+1)'(o_valid), 0);
        chk("rst_res", o_res, 0);
        i_rstn = 1'b1;

        run_op('0, m_p, res, lat);
        chk("t0_res", res, 0);
        chk("t0_lat", (IDW+1)'(lat), (IDW+1)'(LAT));

        run_op(ODW'(1) << 261, m_p, res, lat);
        chk("t2p261_res", res, 1);

        // T = m: every digit step maps m to m, so only the final subtraction can reach 0.
        run_op(ODW'(m_p), m_p, res, lat);
`ifdef MMM_REDC_FINAL_SUB_EN
        chk("tm_res", res, 0);
`else
        chk("tm_res", res, (IDW+1)'(m_p));
`endif

        for (int n = 0; n < 1000; n++) begin
            m_r = rnd256() | (IDW'(1) << 255) | IDW'(1);
            r_r = rnd256() >> 2;
            k_r = {rnd256(), 3'($urandom())};
            t_r = (ODW'(r_r) << 261) + ODW'(k_r) * ODW'(m_r);
            run_op(t_r, m_r, res, lat);
            chk("rand_res", norm(res, m_r), (IDW+1)'(r_r));
`ifndef MMM_REDC_FINAL_SUB_EN
            chk("rand_lt2m", (IDW+1)'(res < ((IDW+1)'(m_r) << 1)), 1);
`endif
        end

        // Backpressure: hold i_ready low for 10 cycles in DONE.
        i_t = (ODW'(7) << 261) + ODW'(12345) * ODW'(m_p);
        i_m = m_p; i_minv = neg_inv(m_p);
        i_ready = 1'b0; i_valid = 1'b1;
        @(posedge i_clk); #1;
        i_valid = 1'b0;
        w = 0;
        while (!o_valid && w < 20) begin @(posedge i_clk); #1; w++; end
        chk("bp_res", norm(o_res, m_p), 7);
        repeat (10) begin
            @(posedge i_clk); #1;
            chk("bp_hold", norm(o_res, m_p), 7);
            chk("bp_valid", (IDW+1)'(o_valid), 1);
            chk("bp_ready", (IDW+1)'(o_ready), 0);
        end
        i_ready = 1'b1;
        @(posedge i_clk); #1;
        chk("bp_valid_drop", (IDW+1)'(o_valid), 0);
        chk("bp_ready_rise", (IDW+1)'(o_ready), 1);

        // Reset pulse during the second ITER cycle.
        i_t = ODW'(5) << 261; i_m = m_p; i_minv = neg_inv(m_p);
        i_valid = 1'b1;
        @(posedge i_clk); #1;
        i_valid = 1'b0;
        @(posedge i_clk); #1;
        i_rstn = 1'b0;
        @(posedge i_clk); #1;
        i_rstn = 1'b1;
        chk("mid_rst_valid", (IDW+1)'(o_valid), 0);
        chk("mid_rst_ready", (IDW+1)'(o_ready), 1);
        chk("mid_rst_res", o_res, 0);
        repeat (6) begin
            @(posedge i_clk); #1;
            chk("mid_rst_no_out", (IDW+1)'(o_valid), 0);
        end
        run_op((ODW'(9) << 261) + ODW'(99) * ODW'(m_p), m_p, res, lat);
        chk("post_rst_res", norm(res, m_p), 9);

        // Back-to-back stream with i_valid and i_ready held high.
        for (int j = 0; j < 4; j++) begin
            bexp[j] = (IDW+1)'(j + 2);
            bt[j]   = (ODW'(j + 2) << 261) + ODW'(j * 1000 + 17) * ODW'(m_p);
        end
        i_m = m_p; i_minv = neg_inv(m_p); i_t = bt[0];
        i_valid = 1'b1; i_ready = 1'b1;
        nin = 0; nout = 0; cyc = 0; last = 0;
        while (nout < 4 && cyc < 100) begin
            afire = i_valid && o_ready;
            ofire = o_valid && i_ready;
            if (ofire) begin
                chk("b2b_res", norm(o_res, m_p), bexp[nout]);
                nout++;
            end
            @(posedge i_clk); #1;
            cyc++;
            if (afire) begin
                if (nin > 0) chk("b2b_gap", (IDW+1)'(cyc - last), (IDW+1)'(PERIOD));
                last = cyc;
                nin++;
                if (nin < 4) i_t = bt[nin];
                else i_valid = 1'b0;
            end
        end
        chk("b2b_nout", (IDW+1)'(nout), 4);
        chk("b2b_nin", (IDW+1)'(nin), 4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog");
    end

endmodule
